// File: rtl/ptr_xfer_sequencer.sv
// Byte/word transfer sequencer for the four up/down pointer registers.
// Drives address select, pointer inc/dec strobes and the 8-bit memory handshake.
module ptr_xfer_sequencer #(
  parameter int NPTR = 4
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    req_valid,
  input  logic [1:0]              req_op,
  input  logic [$clog2(NPTR)-1:0] req_ptr,
  input  logic [15:0]             req_wdata,
  output logic                    req_ready,
  output logic [NPTR-1:0]         addr_sel,
  output logic [NPTR-1:0]         ptr_inc,
  output logic [NPTR-1:0]         ptr_dec,
  input  logic [NPTR-1:0]         ptr_carry_n,
  input  logic [NPTR-1:0]         ptr_borrow_n,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata,
  input  logic                    mem_ready,
  output logic [15:0]             rdata,
  output logic                    rdata_valid,
  output logic                    wrap_err,
  output logic [2:0]              dbg_state
);

  localparam int PW = $clog2(NPTR);

  typedef enum logic [1:0] {
    OP_RDB  = 2'b00,
    OP_WRB  = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_ACC  = 3'd2,
    S_POST = 3'd3,
    S_RESP = 3'd4
  } state_e;

  // Request handshake: a request is taken on a rising edge where
  // req_valid & req_ready; req_ready is high only in IDLE, nothing is queued.
  state_e         state, state_next;
  op_e            op_q;
  logic [PW-1:0]  ptr_q;
  logic [15:0]    wdata_q;
  logic           bc;
  logic           is_read;
  logic [NPTR-1:0] sel_onehot;

  assign is_read    = (op_q == OP_RDB) || (op_q == OP_POP);
  assign sel_onehot = {{(NPTR-1){1'b0}}, 1'b1} << ptr_q;
  assign dbg_state  = state;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= S_IDLE;
      op_q     <= OP_RDB;
      ptr_q    <= '0;
      wdata_q  <= '0;
      bc       <= 1'b0;
      rdata    <= '0;
      wrap_err <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (req_valid) begin
          op_q     <= op_e'(req_op);
          ptr_q    <= req_ptr;
          wdata_q  <= req_wdata;
          bc       <= 1'b0;
          wrap_err <= 1'b0;
        end
        S_PRE: if (!ptr_borrow_n[ptr_q]) wrap_err <= 1'b1;
        S_ACC: if (mem_ready) begin
          if (op_q == OP_RDB) rdata <= {8'h00, mem_rdata};
          if (op_q == OP_POP) begin
            if (bc) rdata[15:8] <= mem_rdata;
            else    rdata[7:0]  <= mem_rdata;
          end
          if (op_q == OP_PUSH && !bc) bc <= 1'b1;
        end
        S_POST: begin
          if (!ptr_carry_n[ptr_q]) wrap_err <= 1'b1;
          if (op_q == OP_POP && !bc) bc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    addr_sel    = '0;
    ptr_inc     = '0;
    ptr_dec     = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = 8'h00;
    rdata_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (op_e'(req_op) == OP_PUSH) ? S_PRE : S_ACC;
      end
      S_PRE: begin
        addr_sel   = sel_onehot;
        ptr_dec    = sel_onehot;
        state_next = S_ACC;
      end
      S_ACC: begin
        addr_sel = sel_onehot;
        mem_rd   = is_read;
        mem_wr   = !is_read;
        // PUSH16 stores high byte first so the low byte lands at the lower address
        if (op_q == OP_WRB)  mem_wdata = wdata_q[7:0];
        if (op_q == OP_PUSH) mem_wdata = bc ? wdata_q[7:0] : wdata_q[15:8];
        if (mem_ready) begin
          if (op_q == OP_PUSH) state_next = bc ? S_RESP : S_PRE;
          else                 state_next = S_POST;
        end
      end
      S_POST: begin
        addr_sel   = sel_onehot;
        ptr_inc    = sel_onehot;
        state_next = (op_q == OP_POP && !bc) ? S_ACC : S_RESP;
      end
      S_RESP: begin
        addr_sel    = sel_onehot;
        rdata_valid = 1'b1;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ptr_xfer_sequencer.sv
// Directed bench for ptr_xfer_sequencer with a pointer-register and byte-memory model.
module tb_ptr_xfer_sequencer;

  logic        clk = 1'b0;
  logic        clear;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [1:0]  req_ptr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic [3:0]  addr_sel, ptr_inc, ptr_dec, ptr_carry_n, ptr_borrow_n;
  logic        mem_rd, mem_wr, mem_ready;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [15:0] rdata;
  logic        rdata_valid, wrap_err;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  ptr_xfer_sequencer #(.NPTR(4)) dut (
    .clk(clk), .clear(clear), .req_valid(req_valid), .req_op(req_op),
    .req_ptr(req_ptr), .req_wdata(req_wdata), .req_ready(req_ready),
    .addr_sel(addr_sel), .ptr_inc(ptr_inc), .ptr_dec(ptr_dec),
    .ptr_carry_n(ptr_carry_n), .ptr_borrow_n(ptr_borrow_n),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rdata(rdata),
    .rdata_valid(rdata_valid), .wrap_err(wrap_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pointer register model, loaded from the stimulus side via ld_*
  logic [15:0] ptr_reg [4];
  logic        ld_en = 1'b0;
  logic [1:0]  ld_idx = 2'd0;
  logic [15:0] ld_val = 16'h0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ld_en && ld_idx == 2'(i)) ptr_reg[i] <= ld_val;
      else if (ptr_inc[i])          ptr_reg[i] <= ptr_reg[i] + 16'd1;
      else if (ptr_dec[i])          ptr_reg[i] <= ptr_reg[i] - 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ptr_carry_n[i]  = (ptr_reg[i] != 16'hFFFF);
      ptr_borrow_n[i] = (ptr_reg[i] != 16'h0000);
    end
  end

  // Byte memory with programmable wait states
  logic [7:0]  mem [0:65535];
  logic [15:0] cur_addr;
  int          wait_req = 0;
  int          wait_cnt = 0;

  always_comb begin
    cur_addr = 16'h0;
    for (int i = 0; i < 4; i++) if (addr_sel[i]) cur_addr = ptr_reg[i];
  end

  assign mem_rdata = mem[cur_addr];
  assign mem_ready = (mem_rd || mem_wr) && (wait_cnt >= wait_req);

  always @(posedge clk) begin
    if (mem_rd || mem_wr) wait_cnt <= mem_ready ? 0 : wait_cnt + 1;
  end

  // Scoreboard of expected writes {addr, byte}
  logic [23:0] exp_q[$];
  int inc_cnt [4];
  int dec_cnt [4];
  int rd_cycles = 0;
  int viol = 0;

  initial for (int i = 0; i < 4; i++) begin inc_cnt[i] = 0; dec_cnt[i] = 0; end

  always @(posedge clk) begin
    if (mem_wr && mem_ready) begin
      if (exp_q.size() == 0) chk("wr_unexpected", {8'h0, cur_addr, mem_wdata}, 32'hFFFF_FFFF);
      else chk("wr_addr_data", {8'h0, cur_addr, mem_wdata}, {8'h0, exp_q.pop_front()});
      mem[cur_addr] = mem_wdata;
    end
    if (mem_rd) rd_cycles++;
    for (int i = 0; i < 4; i++) begin
      if (ptr_inc[i]) inc_cnt[i]++;
      if (ptr_dec[i]) dec_cnt[i]++;
    end
  end

  always @(negedge clk) begin
    if ((ptr_inc & ptr_dec) != 4'b0) viol++;
    if (mem_rd && mem_wr) viol++;
    if ($countones(ptr_inc) > 1 || $countones(ptr_dec) > 1) viol++;
  end

  task automatic set_ptr(input logic [1:0] idx, input logic [15:0] val);
    @(negedge clk);
    ld_idx = idx; ld_val = val; ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [1:0] ptr, input logic [15:0] wd,
                       input int waits, output int lat, output logic [3:0] sel);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    wait_req = waits;
    req_op = op; req_ptr = ptr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    sel = addr_sel;
    while (!rdata_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!rdata_valid) chk("rdata_valid_timeout", 32'd0, 32'd1);
  endtask

  int lat, i0, i1, d1, rc;
  logic [3:0] sel;

  initial begin
    clear = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_ptr = 2'd0; req_wdata = 16'h0;
    for (int i = 0; i < 4; i++) ptr_reg[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_addr_sel", {28'b0, addr_sel}, 32'd0);
    chk("rst_strobes", {24'b0, ptr_inc, ptr_dec}, 32'd0);
    chk("rst_mem", {22'b0, mem_rd, mem_wr, mem_wdata}, 32'd0);
    chk("rst_rdata", {14'b0, rdata, rdata_valid, wrap_err}, 32'd0);
    chk("rst_state", {29'b0, dbg_state}, 32'd0);
    @(negedge clk);
    clear = 1'b0;

    // POP16 on SP
    mem[16'h01FE] = 8'h34; mem[16'h01FF] = 8'h12;
    set_ptr(2'd1, 16'h01FE);
    i1 = inc_cnt[1];
    do_op(2'b11, 2'd1, 16'h0, 0, lat, sel);
    chk("pop_lat", lat, 32'd5);
    chk("pop_sel", {28'b0, sel}, 32'b0010);
    chk("pop_rdata", {16'b0, rdata}, 32'h1234);
    chk("pop_wrap", {31'b0, wrap_err}, 32'd0);
    @(negedge clk);
    chk("pop_sp", {16'b0, ptr_reg[1]}, 32'h0200);
    chk("pop_incs", inc_cnt[1] - i1, 32'd2);

    // PUSH16 on SP
    exp_q.push_back({16'h01FF, 8'hBE});
    exp_q.push_back({16'h01FE, 8'hEF});
    d1 = dec_cnt[1];
    do_op(2'b10, 2'd1, 16'hBEEF, 0, lat, sel);
    chk("push_lat", lat, 32'd5);
    chk("push_wrap", {31'b0, wrap_err}, 32'd0);
    @(negedge clk);
    chk("push_sp", {16'b0, ptr_reg[1]}, 32'h01FE);
    chk("push_decs", dec_cnt[1] - d1, 32'd2);

    // RDB on SI with three wait states
    mem[16'h1000] = 8'hA5;
    set_ptr(2'd2, 16'h1000);
    rc = rd_cycles;
    i0 = inc_cnt[2];
    do_op(2'b00, 2'd2, 16'h0, 3, lat, sel);
    chk("rdb_lat", lat, 32'd6);
    chk("rdb_rdata", {16'b0, rdata}, 32'h00A5);
    chk("rdb_sel", {28'b0, sel}, 32'b0100);
    @(negedge clk);
    chk("rdb_rd_cycles", rd_cycles - rc, 32'd4);
    chk("rdb_si", {16'b0, ptr_reg[2]}, 32'h1001);
    chk("rdb_incs", inc_cnt[2] - i0, 32'd1);

    // WRB on DI at 0xFFFF wraps
    set_ptr(2'd3, 16'hFFFF);
    exp_q.push_back({16'hFFFF, 8'h34});
    do_op(2'b01, 2'd3, 16'h1234, 0, lat, sel);
    chk("wrb_lat", lat, 32'd3);
    chk("wrb_wrap", {31'b0, wrap_err}, 32'd1);
    chk("wrb_rdata_hold", {16'b0, rdata}, 32'h00A5);
    @(negedge clk);
    chk("wrb_di", {16'b0, ptr_reg[3]}, 32'h0000);
    chk("wrap_sticky_idle", {31'b0, wrap_err}, 32'd1);

    // Next accept clears wrap_err
    mem[16'h0100] = 8'h5A;
    set_ptr(2'd0, 16'h0100);
    do_op(2'b00, 2'd0, 16'h0, 1, lat, sel);
    chk("rdb2_lat", lat, 32'd4);
    chk("rdb2_wrap_clr", {31'b0, wrap_err}, 32'd0);
    chk("rdb2_rdata", {16'b0, rdata}, 32'h005A);

    // PUSH16 on SP at 0x0000 wraps on the first pre-decrement
    set_ptr(2'd1, 16'h0000);
    exp_q.push_back({16'hFFFF, 8'hCA});
    exp_q.push_back({16'hFFFE, 8'hFE});
    do_op(2'b10, 2'd1, 16'hCAFE, 0, lat, sel);
    chk("push0_lat", lat, 32'd5);
    chk("push0_wrap", {31'b0, wrap_err}, 32'd1);
    @(negedge clk);
    chk("push0_sp", {16'b0, ptr_reg[1]}, 32'hFFFE);

    // Clear during POP16 after the first POST, with busy requests ignored
    mem[16'h0300] = 8'h11; mem[16'h0301] = 8'h22;
    set_ptr(2'd1, 16'h0300);
    i0 = inc_cnt[2];
    @(negedge clk);
    wait_req = 0;
    req_op = 2'b11; req_ptr = 2'd1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_op = 2'b00; req_ptr = 2'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_state", {29'b0, dbg_state}, 32'd2);
    chk("abort_pre_rd", {31'b0, mem_rd}, 32'd1);
    clear = 1'b1;
    #1;
    chk("abort_mem", {30'b0, mem_rd, mem_wr}, 32'd0);
    chk("abort_strobes", {24'b0, ptr_inc, ptr_dec}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_addr_sel", {28'b0, addr_sel}, 32'd0);
    chk("abort_rdata", {15'b0, rdata, rdata_valid}, 32'd0);
    chk("abort_sp", {16'b0, ptr_reg[1]}, 32'h0301);
    chk("busy_ignored_si", inc_cnt[2] - i0, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("post_abort_idle", {29'b0, dbg_state}, 32'd0);
    chk("post_abort_sp", {16'b0, ptr_reg[1]}, 32'h0301);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("invariants", viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
